// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the shared memory port arbiter:
//     instr_*  : instruction-fetch requester (read only)
//     data_*   : data load/store requester
//     mem_*    : the single physical memory/cache port
//     timeout_err : pulse reporting an abandoned transaction
//   modport slave  : the arbiter's view (takes requests, drives the memory port)
//   modport master : the surrounding system's view (requesters plus memory)
interface mem_port_arbiter_if;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_rdata;
    logic        instr_resp;

    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_wdata;
    logic [3:0]  data_byte_enable;
    logic [31:0] data_rdata;
    logic        data_resp;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic        timeout_err;

    modport slave (
        input  instr_read, instr_address,
        output instr_rdata, instr_resp,
        input  data_read, data_write, data_address, data_wdata, data_byte_enable,
        output data_rdata, data_resp,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp,
        output timeout_err
    );

    modport master (
        output instr_read, instr_address,
        input  instr_rdata, instr_resp,
        output data_read, data_write, data_address, data_wdata, data_byte_enable,
        input  data_rdata, data_resp,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp,
        input  timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch and data access.
//   Data requests win arbitration, except that after STARVE_LIMIT
//   consecutive data grants with a fetch pending the fetch is forced
//   through (STARVE_LIMIT = 0 gives strict data priority).
//   Each served requester gets a one-cycle resp pulse with its read data.
//
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : asynchronous active-low reset
//     bus  : mem_port_arbiter_if.slave (instr_*, data_*, mem_*, timeout_err)
//
//   Optional feature macro: MEM_ARB_TIMEOUT_EN
//     Defined   : a busy transaction without mem_resp for TIMEOUT_CYCLES
//                 cycles is abandoned; the requester gets resp with
//                 rdata = 0 and timeout_err pulses.
//     Undefined : busy states wait indefinitely, timeout_err is 0.
//
//   state  | meaning
//   IDLE   | arbitrating between pending requests
//   BUSY_I | fetch strobe on the memory port, waiting for mem_resp
//   BUSY_D | load/store strobe on the memory port, waiting for mem_resp
//   DONE_I | instr_resp pulse, instr_rdata valid
//   DONE_D | data_resp pulse, data_rdata valid
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    localparam int unsigned   SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt;

    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   instr_rdata_q;
    logic [31:0]   data_rdata_q;

    logic          data_req;
    logic          instr_forced;
    logic          grant_d;
    logic          grant_i;
    logic          busy;
    logic          timeout_hit;

    assign data_req = bus.data_read | bus.data_write;
    assign busy     = (state == BUSY_I) || (state == BUSY_D);

    // With STARVE_LIMIT = 0 the counter is stuck at 0 == STARVE_MAX, so the
    // explicit non-zero test is what keeps data strictly ahead.
    assign instr_forced = bus.instr_read && (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned   TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] busy_cnt;
    logic          timeout_q;

    // busy_cnt counts from 0 in the first busy cycle, so the last allowed
    // busy cycle is where it equals TIMEOUT_CYCLES-1. A mem_resp arriving
    // in that same cycle still completes normally.
    assign timeout_hit = busy && !bus.mem_resp && (busy_cnt == TMO_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (grant_d || grant_i) begin
                busy_cnt <= '0;
            end else if (busy) begin
                busy_cnt <= busy_cnt + 1'b1;
            end
            timeout_q <= timeout_hit;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && !instr_forced) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (bus.instr_read) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I: begin
                if (bus.mem_resp || timeout_hit) begin
                    state_nxt = DONE_I;
                end
            end
            BUSY_D: begin
                if (bus.mem_resp || timeout_hit) begin
                    state_nxt = DONE_D;
                end
            end
            DONE_I:  state_nxt = IDLE;
            DONE_D:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture: the memory port is driven only from these registers,
    // so requester activity after the grant cannot disturb the transaction.
    // A simultaneous read+write is issued as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (grant_d) begin
            write_q <= bus.data_write;
            addr_q  <= bus.data_address;
            wdata_q <= bus.data_wdata;
            be_q    <= bus.data_byte_enable;
        end else if (grant_i) begin
            write_q <= 1'b0;
            addr_q  <= bus.instr_address;
            wdata_q <= '0;
            be_q    <= 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.instr_read && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read data is latched per requester so each rdata holds its own last
    // value; an abandoned transaction returns zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            if ((state == BUSY_I) && (bus.mem_resp || timeout_hit)) begin
                instr_rdata_q <= bus.mem_resp ? bus.mem_rdata : 32'h0;
            end
            if ((state == BUSY_D) && (bus.mem_resp || timeout_hit)) begin
                data_rdata_q <= bus.mem_resp ? bus.mem_rdata : 32'h0;
            end
        end
    end

    assign bus.mem_read        = (state == BUSY_I) || ((state == BUSY_D) && !write_q);
    assign bus.mem_write       = (state == BUSY_D) && write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_byte_enable = be_q;

    assign bus.instr_resp  = (state == DONE_I);
    assign bus.instr_rdata = instr_rdata_q;
    assign bus.data_resp   = (state == DONE_D);
    assign bus.data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned TMO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter_if bus0 ();

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.STARVE_LIMIT(0), .TIMEOUT_CYCLES(TMO)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.instr_read        = 1'b0;
        bus.instr_address     = '0;
        bus.data_read         = 1'b0;
        bus.data_write        = 1'b0;
        bus.data_address      = '0;
        bus.data_wdata        = '0;
        bus.data_byte_enable  = '0;
        bus.mem_rdata         = '0;
        bus.mem_resp          = 1'b0;
        bus0.instr_read       = 1'b0;
        bus0.instr_address    = '0;
        bus0.data_read        = 1'b0;
        bus0.data_write       = 1'b0;
        bus0.data_address     = '0;
        bus0.data_wdata       = '0;
        bus0.data_byte_enable = '0;
        bus0.mem_rdata        = '0;
        bus0.mem_resp         = 1'b0;
    endtask

    initial begin
        bit          got_i [10];
        int          ng, ic, dc;
        bit          i_pend, d_rd, d_wr, g_valid, g_d, g_wr;
        logic [31:0] i_addr, d_addr, d_wdata, g_addr, g_wdata, g_rdata;
        logic [3:0]  d_be, g_be;
        int          g_cyc, g_lat, next_arb, starve, off, r;

        clear_inputs();
        rst = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_address", bus.mem_address, 0);
        chk("rst_instr_resp", bus.instr_resp, 0);
        chk("rst_data_resp", bus.data_resp, 0);
        chk("rst_instr_rdata", bus.instr_rdata, 0);
        chk("rst_data_rdata", bus.data_rdata, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        rst = 1'b1;
        tick();

        // lone fetch: request at cycle 0, mem_resp at cycle 3
        bus.instr_read    = 1'b1;
        bus.instr_address = 32'h60;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("fetch_mem_read", bus.mem_read, 1);
            chk("fetch_mem_write", bus.mem_write, 0);
            chk("fetch_mem_address", bus.mem_address, 32'h60);
            chk("fetch_mem_be", bus.mem_byte_enable, 4'hF);
            chk("fetch_no_resp", bus.instr_resp, 0);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h00A00093;
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
        chk("fetch_instr_resp", bus.instr_resp, 1);
        chk("fetch_instr_rdata", bus.instr_rdata, 32'h00A00093);
        chk("fetch_done_strobe", bus.mem_read, 0);
        chk("fetch_data_resp", bus.data_resp, 0);
        bus.instr_read = 1'b0;
        tick();
        chk("fetch_resp_pulse", bus.instr_resp, 0);
        chk("fetch_rdata_hold", bus.instr_rdata, 32'h00A00093);
        tick();

        // reset mid BUSY_D
        bus.data_write       = 1'b1;
        bus.data_address     = 32'h200;
        bus.data_wdata       = 32'h12345678;
        bus.data_byte_enable = 4'hF;
        tick();
        chk("rstmid_write_on", bus.mem_write, 1);
        #2;
        rst            = 1'b0;
        bus.data_write = 1'b0;
        #1;
        chk("rstmid_write_async", bus.mem_write, 0);
        chk("rstmid_rdata_clr", bus.instr_rdata, 0);
        tick();
        rst = 1'b1;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h55AA55AA;
        tick();
        bus.mem_resp = 1'b0;
        chk("rstmid_no_resp1", bus.data_resp, 0);
        chk("rstmid_idle", bus.mem_write, 0);
        tick();
        chk("rstmid_no_resp2", bus.data_resp, 0);
        chk("rstmid_rdata", bus.data_rdata, 0);

        // simultaneous requests: data first, fetch strobe 2 cycles after data_resp
        bus.instr_read    = 1'b1;
        bus.instr_address = 32'h80;
        bus.data_read     = 1'b1;
        bus.data_address  = 32'h300;
        tick();
        chk("sim_data_first", bus.mem_read, 1);
        chk("sim_data_addr", bus.mem_address, 32'h300);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hCAFE0001;
        tick();
        bus.mem_resp = 1'b0;
        chk("sim_data_resp", bus.data_resp, 1);
        chk("sim_data_rdata", bus.data_rdata, 32'hCAFE0001);
        chk("sim_instr_wait", bus.instr_resp, 0);
        bus.data_read = 1'b0;
        tick();
        chk("sim_gap", bus.mem_read, 0);
        tick();
        chk("sim_instr_strobe", bus.mem_read, 1);
        chk("sim_instr_addr", bus.mem_address, 32'h80);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hCAFE0002;
        tick();
        bus.mem_resp = 1'b0;
        chk("sim_instr_resp", bus.instr_resp, 1);
        chk("sim_instr_rdata", bus.instr_rdata, 32'hCAFE0002);
        chk("sim_data_rdata_hold", bus.data_rdata, 32'hCAFE0001);
        bus.instr_read = 1'b0;
        tick();

        // store pass-through, inputs changed mid-busy
        bus.data_write       = 1'b1;
        bus.data_address     = 32'h104;
        bus.data_wdata       = 32'h0000AB00;
        bus.data_byte_enable = 4'b0010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("st_mem_write", bus.mem_write, 1);
            chk("st_mem_read", bus.mem_read, 0);
            chk("st_mem_address", bus.mem_address, 32'h104);
            chk("st_mem_wdata", bus.mem_wdata, 32'h0000AB00);
            chk("st_mem_be", bus.mem_byte_enable, 4'b0010);
            bus.data_address     = $urandom;
            bus.data_wdata       = $urandom;
            bus.data_byte_enable = 4'b1101;
            bus.data_read        = 1'b1;
            bus.data_write       = 1'b0;
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        tick();
        bus.mem_resp   = 1'b0;
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        chk("st_data_resp", bus.data_resp, 1);
        chk("st_strobe_off", bus.mem_write, 0);
        tick();

        // starvation guard with STARVE_LIMIT = 4
        bus.instr_read    = 1'b1;
        bus.instr_address = 32'h40;
        bus.data_read     = 1'b1;
        bus.data_address  = 32'h500;
        ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            tick();
            if (bus.instr_resp || bus.data_resp) begin
                got_i[ng] = bus.instr_resp;
                ng++;
            end
            bus.mem_resp  = bus.mem_read | bus.mem_write;
            bus.mem_rdata = $urandom;
        end
        chk("starve_grants_seen", ng, 10);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("starve_order_%0d", i), got_i[i], (i % 5 == 4) ? 1 : 0);
        end
        bus.instr_read = 1'b0;
        bus.data_read  = 1'b0;
        bus.mem_resp   = 1'b0;
        tick();
        tick();

        // strict data priority with STARVE_LIMIT = 0
        bus0.instr_read    = 1'b1;
        bus0.instr_address = 32'h44;
        bus0.data_write    = 1'b1;
        bus0.data_address  = 32'h600;
        ic = 0;
        dc = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            ic += bus0.instr_resp;
            dc += bus0.data_resp;
            bus0.mem_resp = bus0.mem_read | bus0.mem_write;
        end
        chk("strict_instr_blocked", ic, 0);
        chk("strict_data_count", dc, 20);
        bus0.data_write = 1'b0;
        for (int c = 0; c < 12 && ic == 0; c++) begin
            tick();
            ic += bus0.instr_resp;
            bus0.mem_resp = bus0.mem_read | bus0.mem_write;
        end
        chk("strict_instr_after", ic, 1);
        bus0.instr_read = 1'b0;
        bus0.mem_resp   = 1'b0;
        tick();

        // fetch with no memory answer
        bus.instr_read    = 1'b1;
        bus.instr_address = 32'h90;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= TMO; c++) begin
            tick();
            bus.mem_rdata = $urandom;
            chk("tmo_strobe", bus.mem_read, 1);
            chk("tmo_err_low", bus.timeout_err, 0);
        end
        tick();
        chk("tmo_instr_resp", bus.instr_resp, 1);
        chk("tmo_instr_rdata", bus.instr_rdata, 0);
        chk("tmo_err_pulse", bus.timeout_err, 1);
        chk("tmo_strobe_drop", bus.mem_read, 0);
        bus.instr_read = 1'b0;
        tick();
        chk("tmo_err_clear", bus.timeout_err, 0);
        chk("tmo_resp_clear", bus.instr_resp, 0);
        chk("tmo_idle", bus.mem_read, 0);
`else
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.mem_rdata = $urandom;
            chk("wait_strobe", bus.mem_read, 1);
            chk("wait_no_resp", bus.instr_resp, 0);
            chk("wait_no_err", bus.timeout_err, 0);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h00000013;
        tick();
        bus.mem_resp = 1'b0;
        chk("wait_instr_resp", bus.instr_resp, 1);
        chk("wait_instr_rdata", bus.instr_rdata, 32'h13);
        bus.instr_read = 1'b0;
        tick();
`endif

        // randomized traffic against a transaction-level model
        clear_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_pend   = 1'b0;
        d_rd     = 1'b0;
        d_wr     = 1'b0;
        g_valid  = 1'b0;
        g_cyc    = 0;
        g_lat    = 0;
        next_arb = 0;
        starve   = 0;
        i_addr   = '0;
        d_addr   = '0;
        d_wdata  = '0;
        d_be     = '0;
        for (int n = 1; n <= 2000; n++) begin
            tick();
            chk("rnd_timeout_err", bus.timeout_err, 0);
            if (g_valid) begin
                off = n - g_cyc;
                if (off <= g_lat) begin
                    chk("rnd_mem_read", bus.mem_read, !g_wr);
                    chk("rnd_mem_write", bus.mem_write, g_wr);
                    chk("rnd_mem_address", bus.mem_address, g_addr);
                    chk("rnd_mem_be", bus.mem_byte_enable, g_be);
                    if (g_d) chk("rnd_mem_wdata", bus.mem_wdata, g_wdata);
                    chk("rnd_busy_iresp", bus.instr_resp, 0);
                    chk("rnd_busy_dresp", bus.data_resp, 0);
                end else begin
                    chk("rnd_done_read", bus.mem_read, 0);
                    chk("rnd_done_write", bus.mem_write, 0);
                    chk("rnd_done_iresp", bus.instr_resp, !g_d);
                    chk("rnd_done_dresp", bus.data_resp, g_d);
                    if (g_d) begin
                        chk("rnd_data_rdata", bus.data_rdata, g_rdata);
                        d_rd = 1'b0;
                        d_wr = 1'b0;
                    end else begin
                        chk("rnd_instr_rdata", bus.instr_rdata, g_rdata);
                        i_pend = 1'b0;
                    end
                    g_valid  = 1'b0;
                    next_arb = n + 1;
                end
            end else begin
                chk("rnd_idle_read", bus.mem_read, 0);
                chk("rnd_idle_write", bus.mem_write, 0);
                chk("rnd_idle_iresp", bus.instr_resp, 0);
                chk("rnd_idle_dresp", bus.data_resp, 0);
            end

            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
                r       = $urandom_range(0, 9);
                d_rd    = (r < 5) || (r == 9);
                d_wr    = (r >= 5);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(0, 15));
            end
            bus.instr_read       = i_pend;
            bus.instr_address    = i_addr;
            bus.data_read        = d_rd;
            bus.data_write       = d_wr;
            bus.data_address     = d_addr;
            bus.data_wdata       = d_wdata;
            bus.data_byte_enable = d_be;

            if (!g_valid && n >= next_arb) begin
                if ((d_rd || d_wr) && !(i_pend && LIMIT != 0 && starve == LIMIT)) begin
                    g_valid = 1'b1;
                    g_d     = 1'b1;
                    g_wr    = d_wr;
                    g_addr  = d_addr;
                    g_wdata = d_wdata;
                    g_be    = d_be;
                    if (i_pend && starve < LIMIT) starve++;
                end else if (i_pend) begin
                    g_valid = 1'b1;
                    g_d     = 1'b0;
                    g_wr    = 1'b0;
                    g_addr  = i_addr;
                    g_wdata = '0;
                    g_be    = 4'hF;
                    starve  = 0;
                end
                if (g_valid) begin
                    g_cyc   = n;
                    g_lat   = $urandom_range(1, 4);
                    g_rdata = $urandom;
                end
            end

            off = n - g_cyc;
            if (g_valid && off == g_lat) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = g_rdata;
            end else begin
                bus.mem_resp  = (!g_valid || off == 0) && ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one physical memory port between the pipeline's instruction-fetch and data-access requesters. Registered requests go through a small FSM. Data requests have priority, and a bounded starvation guard protects instruction fetch. The block sits between the datapath's instr_mem_*/data_mem_* signals and the single memory/cache port, and returns a one-cycle resp pulse to whichever requester was served.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while instr_read is pending before instruction is forced; 0 = strict data priority
TIMEOUT_CYCLES, 255, cycles allowed in a busy state without mem_resp (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
instr_read  in  1  instruction fetch request, held until instr_resp
instr_address  in  32  fetch address
instr_rdata  out  32  fetch data, valid while instr_resp=1
instr_resp  out  1  one-cycle completion pulse
data_read  in  1  data load request, held until data_resp
data_write  in  1  data store request, held until data_resp
data_address  in  32  load/store address
data_wdata  in  32  store data
data_byte_enable  in  4  store byte mask
data_rdata  out  32  load data, valid while data_resp=1
data_resp  out  1  one-cycle completion pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  32  memory address
mem_wdata  out  32  memory write data
mem_byte_enable  out  4  memory byte mask
mem_rdata  in  32  memory read data, valid with mem_resp
mem_resp  in  1  memory completion pulse
timeout_err  out  1  one-cycle pulse on an abandoned transaction; tied 0 without the optional feature

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Reset (rst=0, async):
  - state=IDLE; starvation counter=0.
  - All mem_* outputs 0; all *_resp 0; *_rdata 0; timeout_err 0.
  - An in-flight memory transaction is abandoned. mem_resp arriving later in IDLE is ignored.
- IDLE arbitration (evaluated each cycle):
  - If data_read|data_write and NOT (instr_read and starve_cnt==STARVE_LIMIT and STARVE_LIMIT!=0): capture data_address, data_wdata, data_byte_enable and op into request regs, go to BUSY_D.
  - Else if instr_read: capture instr_address, byte_enable=4'b1111, op=read, go to BUSY_I.
  - Else stay in IDLE.
- data_read and data_write asserted together is illegal; the write is issued.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while instr_read=1.
  - Clears on each instruction grant.
- BUSY_x:
  - mem_read/mem_write driven from the captured op; mem_address/mem_wdata/mem_byte_enable driven from the captured regs.
  - Outputs are stable for the whole state; requester inputs are ignored after capture.
  - On mem_resp=1: register mem_rdata, go to DONE_x.
- DONE_x:
  - mem_read=mem_write=0.
  - x_resp=1 for exactly this cycle, with x_rdata = registered data.
  - Next state is IDLE. The requester must drop or refresh its request in this cycle.
- Outside DONE, *_rdata holds its last value; *_resp is 0.
- Latency with mem_resp after k cycles of strobe (request seen in IDLE at cycle 0):
  - Strobe asserted cycles 1..k, mem_resp at cycle k.
  - resp at cycle k+1.
  - Earliest next strobe at cycle k+3 (IDLE at k+2).
- mem_resp outside BUSY states is ignored.
- Only one of mem_read/mem_write is ever 1; both are 0 in IDLE/DONE.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A busy counter clears on entering BUSY_x and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_resp: drop the strobes and go to DONE_x.
  - In DONE_x: x_resp=1, x_rdata=32'h0, timeout_err=1 for that cycle.
- Not defined: no counter; BUSY_x waits indefinitely; timeout_err constant 0.

Test Plan:
- Reset mid-BUSY_D:
  - rst low during a store → mem_write=0 asynchronously, state IDLE.
  - mem_resp pulse after rst release → no data_resp.
- Lone fetch:
  - instr_read=1, addr 0x60, mem_resp at cycle 3 with 0x00A00093.
  - Expect mem_read cycles 1..3, mem_address=0x60, instr_resp=1 and instr_rdata=0x00A00093 at cycle 4.
- Simultaneous requests:
  - instr_read and data_read both asserted at cycle 0.
  - Expect data served first, instr_read strobe beginning 2 cycles after data_resp.
- Store pass-through:
  - data_write, addr 0x104, wdata 0x0000AB00, mask 4'b0010.
  - Expect mem_write=1 and identical mem_address/mem_wdata/mem_byte_enable held until mem_resp.
  - Expect data_resp one cycle later; changing the data_* inputs mid-BUSY has no effect.
- Starvation, STARVE_LIMIT=4:
  - data requests continuously asserted, instr_read held.
  - Expect grant order D,D,D,D,I,D...
  - With STARVE_LIMIT=0, instr is never served while data is asserted.
- Timeout, with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - Fetch with no mem_resp → after 8 busy cycles, instr_resp=1, instr_rdata=0, timeout_err=1 for one cycle, then IDLE.
